// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: the active-low hex glyph table used by both the
// segment encoder and the scan decoder, so the two directions cannot disagree.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   typedef struct packed {
      logic       err;
      logic [3:0] nibble;
   } seg7_dec_t;

   localparam seg7_t SEG7_BLANK = 7'h7F;
   localparam seg7_t SEG7_DASH  = 7'h3F;

   // Index is the hex value; bit0 = segment a ... bit6 = segment g, 0 = lit.
   localparam seg7_t SEG7_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the segment encoder: maps an active-low pattern back
// to its hex nibble, flagging anything that is not one of the 16 glyphs.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  seg7_t     i_seg,
   output seg7_dec_t o_dec
);

   always_comb begin
      // NOTE: defaults first so every path assigns o_dec and no latch is inferred.
      o_dec.nibble = 4'd0;
      o_dec.err    = 1'b1;
      for (int g = 0; g < 16; g++) begin
         if (i_seg == SEG7_GLYPH[g]) begin
            o_dec.nibble = 4'(g);
            o_dec.err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 7-segment bus: debounces each digit, assembles a
// frame of DIGITS nibbles and offers it on a valid/ready output.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  seg7_t                 seg_in,
   input  logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   out_value,
   output logic [DIGITS-1:0]     out_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun
);

   localparam int             CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

   seg7_t                 r_seg_q;
   logic [DIGITS-1:0]     r_sel_q;
   logic [CW-1:0]         r_cnt;
   logic                  r_armed;
   logic [4*DIGITS-1:0]   r_slot_val;
   logic [DIGITS-1:0]     r_slot_err;
   logic [DIGITS-1:0]     r_mask;

   seg7_dec_t             w_dec;
   logic                  w_same;
   logic                  w_onehot;
   logic                  w_capture;
   logic                  w_frame_done;
   logic [DIGITS-1:0]     w_mask_base;

   seg7_glyph_decode u_decode (
      .i_seg (r_seg_q),
      .o_dec (w_dec)
   );

   // The sample about to be registered is compared with the one already held,
   // so the counter reaches its maximum on the last of STABLE_CYCLES equal samples.
   assign w_same       = ({seg_in, dig_sel} == {r_seg_q, r_sel_q});
   assign w_onehot     = (r_sel_q != '0) && ((r_sel_q & (r_sel_q - DIGITS'(1))) == '0);
   assign w_capture    = (r_cnt == CNT_MAX) && r_armed && w_onehot;
   assign w_frame_done = &r_mask;
   assign w_mask_base  = w_frame_done ? '0 : r_mask;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: slot storage is cleared on reset as well, so a discarded partial
         // frame can never leak into the next one.
         r_seg_q    <= '0;
         r_sel_q    <= '0;
         r_cnt      <= '0;
         r_armed    <= 1'b0;
         r_slot_val <= '0;
         r_slot_err <= '0;
         r_mask     <= '0;
         out_value  <= '0;
         out_err    <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; every read below sees the
         // pre-edge value, which the capture/completion ordering depends on.
         r_seg_q <= seg_in;
         r_sel_q <= dig_sel;

         if (!w_same) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_armed <= 1'b0;
         end

         for (int i = 0; i < DIGITS; i++) begin
            if (w_capture && r_sel_q[i]) begin
               r_slot_val[4*i +: 4] <= w_dec.nibble;
               r_slot_err[i]        <= w_dec.err;
            end
         end

         // A capture on the completion edge lands in the freshly cleared mask.
         r_mask <= w_mask_base | (w_capture ? r_sel_q : '0);

         if (w_frame_done) begin
            if (!out_valid || out_ready) begin
               out_value <= r_slot_val;
               out_err   <= r_slot_err;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed and random digit holds feed a
// frame-level reference model; a monitor checks every frame the DUT presents.
module tb_seg_scan_decoder;
   import seg7_pkg::*;

   localparam int DIGITS = 4;
   localparam int STABLE = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [6:0]            seg_in;
   logic [DIGITS-1:0]     dig_sel;
   logic [4*DIGITS-1:0]   out_value;
   logic [DIGITS-1:0]     out_err;
   logic                  out_valid;
   logic                  out_ready;
   logic                  overrun;

   seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_in    (seg_in),
      .dig_sel   (dig_sel),
      .out_value (out_value),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4*DIGITS-1:0] value;
      logic [DIGITS-1:0]   err;
   } frame_t;

   // Reference glyph table written out independently of the design package.
   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   frame_t             exp_q [$];
   logic [3:0]         m_val [DIGITS];
   logic               m_err [DIGITS];
   logic [DIGITS-1:0]  m_mask = '0;
   logic               exp_overrun = 1'b0;
   int                 ready_mode = 0;   // 0 random, 1 held low, 2 held high
   logic [6:0]         prev_seg = 7'h7F;
   logic [DIGITS-1:0]  prev_sel = '0;
   int                 n_checks = 0;
   int                 n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a hold of n samples captures its digit when n >= STABLE and the
   // select is one-hot; a full set of digits forms a frame.
   task automatic model_hold(input logic [6:0] p, input logic [DIGITS-1:0] sel, input int n);
      frame_t f;
      if (n >= STABLE && $onehot(sel)) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (sel[d]) begin
               m_val[d] = 4'd0;
               m_err[d] = 1'b1;
               for (int g = 0; g < 16; g++) begin
                  if (glyph[g] == p) begin
                     m_val[d] = 4'(g);
                     m_err[d] = 1'b0;
                  end
               end
               m_mask[d] = 1'b1;
            end
         end
         if (&m_mask) begin
            for (int d = 0; d < DIGITS; d++) begin
               f.value[4*d +: 4] = m_val[d];
               f.err[d]          = m_err[d];
            end
            if (ready_mode == 1 && exp_q.size() != 0) exp_overrun = 1'b1;
            else exp_q.push_back(f);
            m_mask = '0;
         end
      end
   endtask

   task automatic drive(input logic [6:0] p, input logic [DIGITS-1:0] sel);
      seg_in   = p;
      dig_sel  = sel;
      prev_seg = p;
      prev_sel = sel;
   endtask

   task automatic hold(input logic [6:0] p, input logic [DIGITS-1:0] sel, input int n);
      model_hold(p, sel, n);
      drive(p, sel);
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_hold();
      logic [6:0]        p;
      logic [DIGITS-1:0] sel;
      int                n;
      sel = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      if ($urandom_range(0, 7) == 0) sel = DIGITS'($urandom);
      p = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      n = $urandom_range(1, 7);
      if (p == prev_seg && sel == prev_sel) sel = sel ^ DIGITS'(1);
      hold(p, sel, n);
   endtask

   task automatic rand_frame();
      for (int d = 0; d < DIGITS; d++) hold(glyph[$urandom_range(0, 15)], DIGITS'(1) << d, 6);
   endtask

   task automatic wait_drain();
      int i = 0;
      while ((exp_q.size() != 0 || out_valid) && i < 300) begin
         @(negedge clk);
         i++;
      end
      check("drain_in_time", 32'(i < 300), 32'd1);
   endtask

   // Consumer: random ready, forced high after a bounded wait so no frame drops.
   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wait_cnt = out_valid ? wait_cnt + 1 : 0;
         case (ready_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 1) == 1) || (wait_cnt >= 5);
         endcase
      end
   end

   // Monitor: every presented frame must match the head of the scoreboard.
   always @(negedge clk) begin
      frame_t f;
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h/%0h with nothing expected", out_value, out_err);
         end else if (out_ready) begin
            f = exp_q.pop_front();
            check("frame_value", 32'(out_value), 32'(f.value));
            check("frame_err", 32'(out_err), 32'(f.err));
            check("frame_overrun", 32'(overrun), 32'(exp_overrun));
         end else begin
            check("held_value", 32'(out_value), 32'(exp_q[0].value));
            check("held_err", 32'(out_err), 32'(exp_q[0].err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      seg_in  = SEG7_BLANK;
      dig_sel = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_value", 32'(out_value), 32'd0);
      check("reset_err", 32'(out_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Loopback 1,2,3,4 -> 16'h4321.
      for (int d = 0; d < DIGITS; d++) hold(glyph[d + 1], DIGITS'(1) << d, 6);
      wait_drain();

      // Timing: digits 1..3 filled, then digit 0 = 7 first sampled at edge k.
      for (int d = 1; d < DIGITS; d++) hold(glyph[d + 8], DIGITS'(1) << d, 6);
      model_hold(glyph[7], DIGITS'(1), STABLE + 2);
      drive(glyph[7], DIGITS'(1));
      for (int j = 1; j <= STABLE + 2; j++) begin
         @(negedge clk);
         if (j == STABLE + 1) check("timing_not_yet", 32'(out_valid), 32'd0);
         if (j == STABLE + 2) check("timing_valid", 32'(out_valid), 32'd1);
      end
      wait_drain();

      // Glitch on digit 2, then a non-one-hot select held long.
      hold(glyph[5], 4'b0100, 3);
      hold(glyph[8], 4'b0100, 4);
      hold(glyph[3], 4'b0011, 10);
      hold(glyph[0], 4'b0001, 6);
      hold(glyph[1], 4'b0010, 6);
      hold(glyph[15], 4'b1000, 6);
      wait_drain();

      // Dash on digit 1 is not a glyph.
      hold(glyph[10], 4'b0001, 6);
      hold(SEG7_DASH, 4'b0010, 6);
      hold(glyph[12], 4'b0100, 6);
      hold(glyph[13], 4'b1000, 6);
      wait_drain();

      // Backpressure: the second frame is dropped, the first is held.
      ready_mode = 1;
      @(negedge clk);
      rand_frame();
      rand_frame();
      repeat (2) @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_value", 32'(out_value), 32'(exp_q[0].value));
      check("bp_overrun", 32'(overrun), 32'd1);
      ready_mode = 2;
      @(negedge clk);
      @(negedge clk);
      check("bp_valid_drop", 32'(out_valid), 32'd0);
      ready_mode = 0;
      wait_drain();

      // Reset after two captured digits discards them and clears overrun.
      hold(glyph[9], 4'b0001, 6);
      hold(glyph[10], 4'b0010, 6);
      rst_n = 1'b0;
      drive(SEG7_BLANK, '0);
      @(negedge clk);
      m_mask      = '0;
      exp_overrun = 1'b0;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_value", 32'(out_value), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      hold(glyph[11], 4'b0100, 6);
      hold(glyph[12], 4'b1000, 6);
      repeat (8) @(negedge clk);
      check("partial_after_reset", 32'(out_valid), 32'd0);
      hold(glyph[6], 4'b0001, 6);
      hold(glyph[14], 4'b0010, 6);
      wait_drain();

      // Random holds of mixed lengths, selects and patterns.
      repeat (150) rand_hold();
      rand_frame();
      wait_drain();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("final_overrun", 32'(overrun), 32'(exp_overrun));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
